core_reg_sequencer: RTL and testbench
=====================================

CORE_REG_SEQUENCER -- requirements
Module: core_reg_sequencer

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum EXEC cycles spent waiting for alu_done before abort.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port op_valid  input  1  operation request.
REQ-005 SHALL have port op_ready  output  1  sequencer accepts an operation this cycle.
REQ-006 SHALL have ports op_src_a, op_src_b, op_dst  input  4 each  register-file source A, source B and destination addresses.
REQ-007 SHALL have ports op_we, op_pc_inc  input  1 each  write result to op_dst; advance PC after the op.
REQ-008 SHALL have port rf_addr_read  output  4  register-file read address.
REQ-009 SHALL have port rf_data_read  input  16  register-file read data, combinational from rf_addr_read.
REQ-010 SHALL have ports rf_addr_write  output  4, rf_data_write  output  16, rf_write_enable  output  1, rf_pc_inc  output  1  register-file write/PC controls.
REQ-011 SHALL have ports alu_start  output  1, alu_a  output  16, alu_b  output  16  ALU launch and operands.
REQ-012 SHALL have ports alu_done  input  1, alu_result  input  16  ALU completion and result.
REQ-013 SHALL have ports busy  output  1 (state != IDLE), timeout  output  1 (one-cycle abort pulse).

Function
REQ-014 SHALL implement states IDLE, READ_A, READ_B, EXEC, WRITE.
REQ-015 IDLE: op_ready=1; op_valid=1 -> latch src_a/src_b/dst/we/pc_inc, go READ_A; otherwise stay.
REQ-016 op_ready SHALL be 0 in every state except IDLE; a new op is not accepted in the WRITE cycle.
REQ-017 READ_A: rf_addr_read=latched src_a; register rf_data_read into operand A at cycle end; go READ_B.
REQ-018 READ_B: rf_addr_read=latched src_b; register operand B; go EXEC.
REQ-019 rf_addr_read SHALL be 0 in IDLE, EXEC and WRITE.
REQ-020 alu_a/alu_b SHALL be driven from the operand registers, held stable from EXEC entry until the next accepted op.
REQ-021 EXEC: alu_start=1 only in the first EXEC cycle; alu_done is sampled in every EXEC cycle, including the first.
REQ-022 EXEC, alu_done=1: register alu_result; go WRITE.
REQ-023 EXEC wait counter: when alu_done=1 has not been seen after WAIT_MAX EXEC cycles, SHALL go IDLE, pulse timeout for 1 cycle, and perform no write and no PC increment.
REQ-024 WRITE: rf_addr_write=dst, rf_data_write=captured result, rf_write_enable=we AND (dst<=11); go IDLE.
REQ-025 dst 12..15 (constant/bus slots) SHALL never assert rf_write_enable.
REQ-026 WRITE: rf_pc_inc=pc_inc, except 0 when rf_write_enable=1 and dst==11 (a PC write overrides the increment).
REQ-027 rf_write_enable and rf_pc_inc SHALL be 0 outside WRITE; rf_addr_write/rf_data_write are 0 outside WRITE.
REQ-028 Latency: accept at T0, READ_A T1, READ_B T2, EXEC T3 (done at T3), WRITE T4, op_ready again T5; minimum 5 cycles per op.
REQ-029 src_a==src_b or src==dst SHALL require no special handling; reads always return pre-write values.

Reset
REQ-030 rst=1 SHALL force IDLE, clear the operand/result/latched-field registers and the wait counter, and drive all outputs to 0 (op_ready=0 during rst, 1 on the first cycle after).
REQ-031 rst in any state SHALL abandon the op: no write, no PC increment, no timeout pulse.

Verification
REQ-032 Reg file r1=0x0005, r2=0x0003; op src_a=1 src_b=2 dst=3 we=1 pc_inc=1; ALU returns 0x0008 at first EXEC -> alu_a=5, alu_b=3, WRITE at T4 with addr 3, data 0x0008, we=1, pc_inc=1; op_ready=1 at T5.
REQ-033 op dst=11 we=1 pc_inc=1, result 0x0100 -> rf_write_enable=1 addr 11 data 0x0100, rf_pc_inc=0.
REQ-034 op dst=13 we=1 -> rf_write_enable=0 in WRITE; rf_pc_inc follows op_pc_inc.
REQ-035 alu_done held 0 -> timeout pulses once after 15 EXEC cycles; no write; op_ready=1 next cycle.
REQ-036 rst asserted during EXEC -> all outputs 0, no write; after release, a new op completes normally.
REQ-037 op_valid held high continuously -> an op is accepted every 5 cycles; op_ready is never 1 in WRITE.

Source files
------------

// File: rtl/core_reg_sequencer.sv
// rtl/core_reg_sequencer.sv - register-file / ALU operation sequencer
//
// Purpose: accepts one operation at a time, reads two register-file operands
// over two cycles, launches the ALU, waits (bounded) for completion and writes
// the result back, optionally advancing the PC.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_valid/op_ready   operation handshake (ready only in IDLE)
//   op_src_a/op_src_b   source register addresses
//   op_dst              destination register address
//   op_we/op_pc_inc     write-back and PC-advance requests
//   rf_addr_read        register-file read address
//   rf_data_read        register-file read data (combinational)
//   rf_addr_write, rf_data_write, rf_write_enable, rf_pc_inc
//                       register-file write-back and PC controls
//   alu_start/alu_a/alu_b  ALU launch pulse and operands
//   alu_done/alu_result    ALU completion and result
//   busy                sequencer is not idle
//   timeout             one-cycle pulse when the ALU wait is abandoned
module core_reg_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_src_a,
    input  logic [3:0]  op_src_b,
    input  logic [3:0]  op_dst,
    input  logic        op_we,
    input  logic        op_pc_inc,
    output logic [3:0]  rf_addr_read,
    input  logic [15:0] rf_data_read,
    output logic [3:0]  rf_addr_write,
    output logic [15:0] rf_data_write,
    output logic        rf_write_enable,
    output logic        rf_pc_inc,
    output logic        alu_start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        timeout
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_A = 3'd1,
        READ_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [3:0]     lat_src_a;
    logic [3:0]     lat_src_b;
    logic [3:0]     lat_dst;
    logic           lat_we;
    logic           lat_pc_inc;
    logic [15:0]    opnd_a;
    logic [15:0]    opnd_b;
    logic [15:0]    result;
    logic [CW-1:0]  wait_cnt;

    // Last allowed EXEC cycle: without alu_done here the op is abandoned.
    logic wait_last;
    assign wait_last = (wait_cnt == CW'(WAIT_MAX - 1));

    // Slots 12..15 are constants/bus windows and are never writable.
    logic write_ok;
    assign write_ok = lat_we && (lat_dst <= 4'd11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_valid) state_next = READ_A;
            READ_A:  state_next = READ_B;
            READ_B:  state_next = EXEC;
            EXEC: begin
                if (alu_done) begin
                    state_next = WRITE;
                end else if (wait_last) begin
                    state_next = IDLE;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_src_a  <= '0;
            lat_src_b  <= '0;
            lat_dst    <= '0;
            lat_we     <= 1'b0;
            lat_pc_inc <= 1'b0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            result     <= '0;
            wait_cnt   <= '0;
        end else begin
            if (state == IDLE && op_valid) begin
                lat_src_a  <= op_src_a;
                lat_src_b  <= op_src_b;
                lat_dst    <= op_dst;
                lat_we     <= op_we;
                lat_pc_inc <= op_pc_inc;
            end
            if (state == READ_A) opnd_a <= rf_data_read;
            if (state == READ_B) opnd_b <= rf_data_read;
            if (state == EXEC && alu_done) result <= alu_result;
            // Counts EXEC cycles already spent; zero on EXEC entry so the
            // first EXEC cycle is recognisable for alu_start.
            if (state == EXEC) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Every output is forced low while rst is high, including the cycle in
    // which rst is first sampled and the state register is not yet IDLE.
    always_comb begin
        op_ready        = 1'b0;
        busy            = 1'b0;
        rf_addr_read    = '0;
        rf_addr_write   = '0;
        rf_data_write   = '0;
        rf_write_enable = 1'b0;
        rf_pc_inc       = 1'b0;
        alu_start       = 1'b0;
        alu_a           = '0;
        alu_b           = '0;
        timeout         = 1'b0;
        if (!rst) begin
            busy  = (state != IDLE);
            alu_a = opnd_a;
            alu_b = opnd_b;
            case (state)
                IDLE:   op_ready = 1'b1;
                READ_A: rf_addr_read = lat_src_a;
                READ_B: rf_addr_read = lat_src_b;
                EXEC: begin
                    alu_start = (wait_cnt == '0);
                    timeout   = !alu_done && wait_last;
                end
                WRITE: begin
                    rf_addr_write   = lat_dst;
                    rf_data_write   = result;
                    rf_write_enable = write_ok;
                    // A write to the PC slot replaces the increment.
                    rf_pc_inc       = lat_pc_inc && !(write_ok && lat_dst == 4'd11);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_reg_sequencer.sv
// tb/tb_core_reg_sequencer.sv - self-checking bench for core_reg_sequencer
module tb_core_reg_sequencer;

    localparam int WAIT_MAX = 15;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_src_a;
    logic [3:0]  op_src_b;
    logic [3:0]  op_dst;
    logic        op_we;
    logic        op_pc_inc;
    logic [3:0]  rf_addr_read;
    logic [15:0] rf_data_read;
    logic [3:0]  rf_addr_write;
    logic [15:0] rf_data_write;
    logic        rf_write_enable;
    logic        rf_pc_inc;
    logic        alu_start;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem [16];

    core_reg_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk             (clk),
        .rst             (rst),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_src_a        (op_src_a),
        .op_src_b        (op_src_b),
        .op_dst          (op_dst),
        .op_we           (op_we),
        .op_pc_inc       (op_pc_inc),
        .rf_addr_read    (rf_addr_read),
        .rf_data_read    (rf_data_read),
        .rf_addr_write   (rf_addr_write),
        .rf_data_write   (rf_data_write),
        .rf_write_enable (rf_write_enable),
        .rf_pc_inc       (rf_pc_inc),
        .alu_start       (alu_start),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_done        (alu_done),
        .alu_result      (alu_result),
        .busy            (busy),
        .timeout         (timeout)
    );

    assign rf_data_read = rf_mem[rf_addr_read];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, op_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, alu_start, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_raddr"}, rf_addr_read, 0);
        chk({tag, "_we"}, rf_write_enable, 0);
        chk({tag, "_pc"}, rf_pc_inc, 0);
        chk({tag, "_waddr"}, rf_addr_write, 0);
        chk({tag, "_wdata"}, rf_data_write, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Runs one operation from its IDLE cycle. delay = EXEC cycle index at
    // which the ALU answers (>= WAIT_MAX means never). rst_k = EXEC cycle
    // index at which reset is asserted (-1 for none). Entered and left just
    // after a rising edge with the sequencer in IDLE.
    task automatic run_op(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] d,
                          input logic we, input logic pci, input int delay,
                          input logic [15:0] res, input logic hold, input int rst_k);
        logic [15:0] ea;
        logic [15:0] eb;
        logic        wr;
        logic        pe;
        logic        done_seen;
        ea = rf_mem[sa];
        eb = rf_mem[sb];
        wr = we && (d < 4'd12);
        pe = pci && !(wr && d == 4'd11);
        done_seen = 1'b0;

        op_valid = 1'b1; op_src_a = sa; op_src_b = sb; op_dst = d;
        op_we = we; op_pc_inc = pci;
        @(negedge clk);
        chk("t0_ready", op_ready, 1);
        chk("t0_busy", busy, 0);
        next_cycle();

        op_valid = hold;
        op_src_a = 4'($urandom); op_src_b = 4'($urandom); op_dst = 4'($urandom);
        op_we = 1'($urandom); op_pc_inc = 1'($urandom);
        @(negedge clk);
        chk("t1_raddr", rf_addr_read, sa);
        chk("t1_ready", op_ready, 0);
        chk("t1_busy", busy, 1);
        next_cycle();

        @(negedge clk);
        chk("t2_raddr", rf_addr_read, sb);
        chk("t2_ready", op_ready, 0);
        next_cycle();

        for (int k = 0; k < WAIT_MAX && !done_seen; k++) begin
            alu_done   = (k == delay);
            alu_result = (k == delay) ? res : 16'($urandom);
            if (k == rst_k) begin
                rst = 1'b1;
                op_valid = 1'b0;
                @(negedge clk);
                chk_all_zero("rst_exec");
                next_cycle();
                rst = 1'b0;
                alu_done = 1'b0;
                @(negedge clk);
                chk("rst_after_ready", op_ready, 1);
                chk("rst_after_we", rf_write_enable, 0);
                chk("rst_after_timeout", timeout, 0);
                next_cycle();
                return;
            end
            @(negedge clk);
            chk("exec_start", alu_start, (k == 0) ? 1 : 0);
            chk("exec_alu_a", alu_a, ea);
            chk("exec_alu_b", alu_b, eb);
            chk("exec_raddr", rf_addr_read, 0);
            chk("exec_ready", op_ready, 0);
            chk("exec_we", rf_write_enable, 0);
            chk("exec_timeout", timeout, (k == WAIT_MAX - 1 && delay != k) ? 1 : 0);
            if (k == delay) done_seen = 1'b1;
            if (k == WAIT_MAX - 1 && !done_seen) op_valid = 1'b0;
            next_cycle();
            alu_done = 1'b0;
        end

        if (!done_seen) begin
            @(negedge clk);
            chk("to_idle_ready", op_ready, 1);
            chk("to_idle_timeout", timeout, 0);
            chk("to_idle_we", rf_write_enable, 0);
            chk("to_idle_pc", rf_pc_inc, 0);
            next_cycle();
            return;
        end

        @(negedge clk);
        chk("wr_addr", rf_addr_write, d);
        chk("wr_data", rf_data_write, res);
        chk("wr_we", rf_write_enable, wr);
        chk("wr_pc", rf_pc_inc, pe);
        chk("wr_ready", op_ready, 0);
        chk("wr_busy", busy, 1);
        chk("wr_alu_a", alu_a, ea);
        if (wr) rf_mem[d] = res;
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_src_a = '0; op_src_b = '0; op_dst = '0;
        op_we = 1'b0; op_pc_inc = 1'b0; alu_done = 1'b0; alu_result = '0;
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
        rf_mem[1] = 16'h0005;
        rf_mem[2] = 16'h0003;

        next_cycle();
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", op_ready, 1);
        chk("post_reset_busy", busy, 0);
        next_cycle();

        // Basic add-style op and PC-slot / constant-slot destinations.
        run_op(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 0, 16'h0008, 1'b0, -1);
        run_op(4'd4, 4'd5, 4'd11, 1'b1, 1'b1, 0, 16'h0100, 1'b0, -1);
        run_op(4'd6, 4'd7, 4'd13, 1'b1, 1'b1, 2, 16'h1234, 1'b0, -1);
        run_op(4'd6, 4'd7, 4'd15, 1'b1, 1'b0, 1, 16'h4321, 1'b0, -1);
        run_op(4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 3, 16'hbeef, 1'b0, -1);
        run_op(4'd3, 4'd1, 4'd12, 1'b0, 1'b1, WAIT_MAX - 1, 16'h0f0f, 1'b0, -1);

        // ALU never answers, then a normal op.
        run_op(4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1000, 16'hdead, 1'b0, -1);
        run_op(4'd5, 4'd3, 4'd8, 1'b1, 1'b1, 0, 16'h00aa, 1'b0, -1);

        // Reset mid-EXEC abandons the op; the next op completes normally.
        run_op(4'd1, 4'd2, 4'd6, 1'b1, 1'b1, 5, 16'h5555, 1'b0, 2);
        run_op(4'd1, 4'd6, 4'd7, 1'b1, 1'b1, 1, 16'h7777, 1'b0, -1);

        // Back-to-back with op_valid held high.
        for (int i = 0; i < 4; i++) begin
            run_op(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'($urandom),
                   0, 16'($urandom), (i != 3), -1);
        end

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = $urandom_range(0, WAIT_MAX + 2);
            run_op(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   dly, 16'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 1 : -1);
        end
        op_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
